// File: rtl/tron_input_ctrl.sv
// tron_input_ctrl -- input front-end for the 4-player light-cycle game.
//   PS/2 keyboard receiver -> scan-code decoder (E0/F0 prefixes) -> 5-bit key code,
//   per-player heading registers, and the game-step tick generator.
// Ports:
//   CLOCK_50      in   system clock, all state on rising edge
//   reset         in   asynchronous active-high reset
//   PS2_KBCLK     in   PS/2 clock from keyboard (asynchronous)
//   PS2_KBDAT     in   PS/2 data from keyboard (asynchronous)
//   KEY_PRESSED   out  code of most recently made, still-held game key, 0 = none
//   clonke        out  one-cycle game tick every RATE_DIV cycles
//   p1d..p4d      out  player headings {0, dir}: 00 up, 01 down, 10 left, 11 right
module tron_input_ctrl #(
  parameter int RATE_DIV    = 5_000_000,
  parameter int PS2_TIMEOUT = 50_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  output logic [4:0] KEY_PRESSED,
  output logic       clonke,
  output logic [2:0] p1d,
  output logic [2:0] p2d,
  output logic [2:0] p3d,
  output logic [2:0] p4d
);

  localparam int NUM_PLR = 4;
  localparam int CW      = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam int TW      = $clog2(PS2_TIMEOUT + 1);

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Scan code -> key code (4*(player-1) + dir + 1); 0 means not a game key.
  // Extended prefix selects the arrow cluster; keypad shares base codes.
  function automatic logic [4:0] key_map(input logic ext, input logic [7:0] sc);
    logic [4:0] k;
    k = 5'd0;
    if (ext) begin
      case (sc)
        8'h75:   k = 5'd1;
        8'h72:   k = 5'd2;
        8'h6B:   k = 5'd3;
        8'h74:   k = 5'd4;
        default: k = 5'd0;
      endcase
    end else begin
      case (sc)
        8'h1D:   k = 5'd5;
        8'h1B:   k = 5'd6;
        8'h1C:   k = 5'd7;
        8'h23:   k = 5'd8;
        8'h43:   k = 5'd9;
        8'h42:   k = 5'd10;
        8'h3B:   k = 5'd11;
        8'h4B:   k = 5'd12;
        8'h75:   k = 5'd13;
        8'h73:   k = 5'd14;
        8'h6B:   k = 5'd15;
        8'h74:   k = 5'd16;
        default: k = 5'd0;
      endcase
    end
    return k;
  endfunction

  // ---------------- state ----------------
  logic [CW-1:0]              cnt_q,      cnt_d;
  logic                       clonke_q,   clonke_d;
  logic [1:0]                 kbclk_s_q,  kbclk_s_d;
  logic [1:0]                 kbdat_s_q,  kbdat_s_d;
  logic                       kbclk_p_q,  kbclk_p_d;
  logic [3:0]                 bit_cnt_q,  bit_cnt_d;
  logic [9:0]                 shift_q,    shift_d;
  logic [TW-1:0]              idle_q,     idle_d;
  logic                       byte_stb_q, byte_stb_d;
  logic [7:0]                 byte_q,     byte_d;
  logic                       ext_q,      ext_d;
  logic                       brk_q,      brk_d;
  logic [4:0]                 key_q,      key_d;
  logic                       hd_stb_q,   hd_stb_d;
  logic [3:0]                 hd_sel_q,   hd_sel_d;   // {player, dir}
  logic [NUM_PLR-1:0][1:0]    hd_q,       hd_d;

  logic       fall;
  logic       frame_ok;
  logic [4:0] code;

  assign fall = kbclk_p_q & ~kbclk_s_q[1];

  always_comb begin
    cnt_d      = cnt_q;
    clonke_d   = 1'b0;
    kbclk_s_d  = {kbclk_s_q[0], PS2_KBCLK};
    kbdat_s_d  = {kbdat_s_q[0], PS2_KBDAT};
    kbclk_p_d  = kbclk_s_q[1];
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idle_d     = idle_q;
    byte_stb_d = 1'b0;
    byte_d     = byte_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_d      = key_q;
    hd_stb_d   = 1'b0;
    hd_sel_d   = hd_sel_q;
    hd_d       = hd_q;
    frame_ok   = 1'b0;
    code       = 5'd0;

    // Tick: registered so it rises RATE_DIV edges after reset release.
    if (cnt_q == CW'(RATE_DIV - 1)) begin
      cnt_d    = '0;
      clonke_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Receiver. shift_q collects start, data[7:0], parity (LSB = oldest);
    // the stop bit is taken straight off the line on the 11th edge.
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        frame_ok   = ~shift_q[0] & (^shift_q[9:1]) & kbdat_s_q[1];
        byte_stb_d = frame_ok;
        if (frame_ok) byte_d = shift_q[8:1];
        bit_cnt_d  = 4'd0;
      end else begin
        shift_d   = {kbdat_s_q[1], shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // Stalled mid-frame: drop the partial byte so the next start bit aligns.
      if (idle_q == TW'(PS2_TIMEOUT - 1)) begin
        idle_d    = '0;
        bit_cnt_d = 4'd0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end

    // Scan decoder: prefixes latch flags, the next plain byte consumes them.
    if (byte_stb_q) begin
      if (byte_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        code = key_map(ext_q, byte_q);
        if (code != 5'd0) begin
          if (brk_q) begin
            // Release only clears if it is the key currently reported.
            if (key_q == code) key_d = 5'd0;
          end else begin
            key_d    = code;
            hd_stb_d = 1'b1;
            hd_sel_d = 4'(code - 5'd1);
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    // Heading: opposite directions differ only in bit 0, so a reversal
    // request is exactly the current heading with bit 0 flipped.
    for (int p = 0; p < NUM_PLR; p++) begin
      if (hd_stb_q && hd_sel_q[3:2] == 2'(p) &&
          hd_sel_q[1:0] != (hd_q[p] ^ 2'b01))
        hd_d[p] = hd_sel_q[1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      clonke_q   <= 1'b0;
      kbclk_s_q  <= 2'b11;   // idle-high so release does not fake an edge
      kbdat_s_q  <= 2'b11;
      kbclk_p_q  <= 1'b1;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      idle_q     <= '0;
      byte_stb_q <= 1'b0;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= 5'd0;
      hd_stb_q   <= 1'b0;
      hd_sel_q   <= '0;
      hd_q       <= {2'b11, 2'b10, 2'b01, 2'b00};
    end else begin
      cnt_q      <= cnt_d;
      clonke_q   <= clonke_d;
      kbclk_s_q  <= kbclk_s_d;
      kbdat_s_q  <= kbdat_s_d;
      kbclk_p_q  <= kbclk_p_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idle_q     <= idle_d;
      byte_stb_q <= byte_stb_d;
      byte_q     <= byte_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      hd_stb_q   <= hd_stb_d;
      hd_sel_q   <= hd_sel_d;
      hd_q       <= hd_d;
    end
  end

  assign KEY_PRESSED = key_q;
  assign clonke      = clonke_q;
  assign p1d         = {1'b0, hd_q[0]};
  assign p2d         = {1'b0, hd_q[1]};
  assign p3d         = {1'b0, hd_q[2]};
  assign p4d         = {1'b0, hd_q[3]};

endmodule

// File: tb/tb_tron_input_ctrl.sv
// Bench for tron_input_ctrl: directed scenarios then randomized PS/2 traffic,
// checked against a byte-level model of the key/heading rules and an edge-count
// model of the game tick.
module tb_tron_input_ctrl;

  localparam int RD  = 4;
  localparam int TMO = 200;
  localparam int HB  = 10;   // system cycles per PS/2 clock half period

  logic       clk = 1'b0;
  logic       reset;
  logic       kbclk, kbdat;
  logic [4:0] key;
  logic       clonke;
  logic [2:0] p1d, p2d, p3d, p4d;

  int n_vec = 0;
  int n_err = 0;

  tron_input_ctrl #(.RATE_DIV(RD), .PS2_TIMEOUT(TMO)) dut (
    .CLOCK_50(clk), .reset(reset), .PS2_KBCLK(kbclk), .PS2_KBDAT(kbdat),
    .KEY_PRESSED(key), .clonke(clonke),
    .p1d(p1d), .p2d(p2d), .p3d(p3d), .p4d(p4d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- tick model: pulse on every RD-th edge after release -----
  int n_edge = 0;
  always @(posedge clk or posedge reset)
    if (reset) n_edge <= 0;
    else       n_edge <= n_edge + 1;

  always @(negedge clk)
    if (!reset) chk("clonke", int'(clonke), (n_edge > 0 && n_edge % RD == 0) ? 1 : 0);

  // ---------------- key/heading model ----------------
  int m_key;
  int m_hd[4];
  bit m_ext, m_brk;

  function automatic int lookup(input bit ext, input logic [7:0] b);
    int k = 0;
    if (ext) begin
      if      (b == 8'h75) k = 1;
      else if (b == 8'h72) k = 2;
      else if (b == 8'h6B) k = 3;
      else if (b == 8'h74) k = 4;
    end else begin
      case (b)
        8'h1D: k = 5;  8'h1B: k = 6;  8'h1C: k = 7;  8'h23: k = 8;
        8'h43: k = 9;  8'h42: k = 10; 8'h3B: k = 11; 8'h4B: k = 12;
        8'h75: k = 13; 8'h73: k = 14; 8'h6B: k = 15; 8'h74: k = 16;
        default: k = 0;
      endcase
    end
    return k;
  endfunction

  task automatic model_reset();
    m_key = 0; m_ext = 0; m_brk = 0;
    for (int i = 0; i < 4; i++) m_hd[i] = i;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int c, pl, d;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    c = lookup(m_ext, b);
    if (c != 0) begin
      if (m_brk) begin
        if (m_key == c) m_key = 0;
      end else begin
        m_key = c;
        pl = (c - 1) / 4;
        d  = (c - 1) % 4;
        // same axis (up/down or left/right) but different direction = reversal
        if (!(d / 2 == m_hd[pl] / 2 && d != m_hd[pl])) m_hd[pl] = d;
      end
    end
    m_ext = 0; m_brk = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".key"}, int'(key), m_key);
    chk({tag, ".p1d"}, int'(p1d), m_hd[0]);
    chk({tag, ".p2d"}, int'(p2d), m_hd[1]);
    chk({tag, ".p3d"}, int'(p3d), m_hd[2]);
    chk({tag, ".p4d"}, int'(p4d), m_hd[3]);
  endtask

  // ---------------- PS/2 driver ----------------
  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kbdat = bits[i];
      repeat (HB) @(negedge clk);
      kbclk = 1'b0;
      repeat (HB) @(negedge clk);
      kbclk = 1'b1;
    end
    kbdat = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send(input logic [7:0] b, input int kind, input string tag);
    logic [10:0] f;
    f[0]   = (kind == 3);
    f[8:1] = b;
    f[9]   = ~(^b) ^ (kind == 1);
    f[10]  = (kind != 2);
    ps2_bits(f, 11);
    repeat (HB) @(negedge clk);
    if (kind == 0) model_byte(b);
    check_state(tag);
  endtask

  task automatic partial_timeout(input int nb, input string tag);
    logic [10:0] f;
    f = 11'($urandom) & 11'h7FE;   // start bit 0
    ps2_bits(f, nb);
    repeat (TMO + 40) @(negedge clk);
    check_state(tag);
  endtask

  logic [7:0] pool[18] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                           8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B, 8'h4B,
                           8'h73, 8'h29};

  initial begin
    int r;
    logic [10:0] f;
    reset = 1'b1; kbclk = 1'b1; kbdat = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.clonke", int'(clonke), 0);
    #2 reset = 1'b0;
    repeat (30) @(negedge clk);

    // directed scenarios
    send(8'h1C, 0, "A");
    send(8'hE0, 0, "E0a");
    send(8'h75, 0, "up");
    send(8'hE0, 0, "E0b");
    send(8'h72, 0, "down_rev");
    send(8'h23, 1, "D_badpar");
    send(8'h23, 2, "D_badstop");
    send(8'h23, 3, "D_badstart");
    send(8'h43, 0, "I");
    send(8'hF0, 0, "F0a");
    send(8'h43, 0, "I_brk");
    send(8'h43, 0, "I2");
    send(8'h75, 0, "kp8");
    send(8'hF0, 0, "F0b");
    send(8'h43, 0, "I_brk2");
    partial_timeout(5, "tmo5");
    send(8'h4B, 0, "L");
    send(8'h29, 0, "unmapped");

    // reset mid-frame with a pending E0: flags and partial byte are lost
    send(8'hE0, 0, "E0c");
    f = 11'b000_1010_1010;
    ps2_bits(f, 5);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    check_state("midrst");
    send(8'h75, 0, "kp8_noext");

    // randomized traffic
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 99);
      if (r < 8)
        partial_timeout($urandom_range(1, 10), "rnd_tmo");
      else if (r < 20)
        send(pool[$urandom_range(0, 17)], $urandom_range(1, 3), "rnd_bad");
      else
        send(pool[$urandom_range(0, 17)], 0, "rnd");
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
